// File: rtl/stc_pkg.sv
// Shared types and constants for the STC frame sequencer and its estimate buffer.
package stc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PILOT = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam int H_W  = 18;
  localparam int DT_W = 6;
  localparam int MU_W = 18;

  localparam logic [H_W-1:0] H_UNITY = 18'h10000;

  typedef struct packed {
    logic [H_W-1:0]  h0_re;
    logic [H_W-1:0]  h0_im;
    logic [H_W-1:0]  h1_re;
    logic [H_W-1:0]  h1_im;
    logic [DT_W-1:0] dtau;
    logic [MU_W-1:0] mu0;
    logic [MU_W-1:0] mu1;
  } est_t;

  // Unity channel gain on both paths, no delay, zero mu.
  function automatic est_t est_reset();
    est_t r;
    r       = '0;
    r.h0_re = H_UNITY;
    r.h1_re = H_UNITY;
    return r;
  endfunction

endpackage

// File: rtl/stc_est_buffer.sv
// Shadow/active double buffer for estimator outputs; shadow is promoted on load,
// with same-cycle bypass and stale detection when nothing new has arrived.
module stc_est_buffer
  import stc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clkEn,
  input  logic estValid,
  input  logic load,
  input  est_t est_bus,
  output est_t active,
  output logic stale
);

  est_t shadow;
  logic fresh;

  assign stale = load & ~fresh & ~estValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= est_reset();
      active <= est_reset();
      fresh  <= 1'b0;
    end else if (clkEn) begin
      if (estValid) shadow <= est_bus;
      if (load) begin
        if (estValid)   active <= est_bus;
        else if (fresh) active <= shadow;
      end
      // A load consumes the estimate, including one bypassed in the same cycle.
      fresh <= load ? 1'b0 : (fresh | estValid);
    end
  end

endmodule

// File: rtl/stc_frame_sequencer.sv
// Per-frame pilot/data sequencer: tracks bit periods, swaps estimates at the
// pilot->data boundary, and issues startFrame/frameDone and consumer enables.
module stc_frame_sequencer
  import stc_pkg::*;
#(
  parameter int PILOT_BITS = 128,
  parameter int DATA_BITS  = 3200,
  parameter int CNT_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic        start,
  input  logic        sampleEn,
  input  logic        estValid,
  input  logic [17:0] h0InReal,
  input  logic [17:0] h0InImag,
  input  logic [17:0] h1InReal,
  input  logic [17:0] h1InImag,
  input  logic [5:0]  deltaTauIn,
  input  logic [17:0] mu0In,
  input  logic [17:0] mu1In,
  output logic [17:0] h0EstReal,
  output logic [17:0] h0EstImag,
  output logic [17:0] h1EstReal,
  output logic [17:0] h1EstImag,
  output logic [5:0]  deltaTauEst,
  output logic [17:0] ch0Mu,
  output logic [17:0] ch1Mu,
  output logic        startFrame,
  output logic        pilotEn,
  output logic        dataEn,
  output logic        frameDone,
  output logic [15:0] frameCount,
  input  logic        clearErrors,
  output logic        earlyStart,
  output logic        estStale
);

  localparam logic [CNT_W-1:0] PILOT_LAST = CNT_W'(PILOT_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             terminal, load, sf_nx, fd_nx, early_set, count_inc, stale;
  est_t             est_bus, active;

  // cnt holds bit periods remaining in the field minus one.
  assign terminal = (cnt == '0);
  assign pilotEn  = sampleEn & clkEn & (state == ST_PILOT);
  assign dataEn   = sampleEn & clkEn & (state == ST_DATA);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    sf_nx     = 1'b0;
    fd_nx     = 1'b0;
    early_set = 1'b0;
    count_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_PILOT;
          cnt_nx   = PILOT_LAST;
        end
      end
      ST_PILOT: begin
        if (start) begin
          cnt_nx = PILOT_LAST;
        end else if (sampleEn) begin
          if (terminal) begin
            state_nx = ST_DATA;
            cnt_nx   = DATA_LAST;
            load     = 1'b1;
            sf_nx    = 1'b1;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (sampleEn && terminal) begin
          fd_nx     = 1'b1;
          count_inc = 1'b1;
          state_nx  = start ? ST_PILOT : ST_IDLE;
          cnt_nx    = start ? PILOT_LAST : '0;
        end else if (start) begin
          early_set = 1'b1;
          state_nx  = ST_PILOT;
          cnt_nx    = PILOT_LAST;
        end else if (sampleEn) begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (clkEn) begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      startFrame <= 1'b0;
      frameDone  <= 1'b0;
      frameCount <= '0;
      earlyStart <= 1'b0;
      estStale   <= 1'b0;
    end else if (clkEn) begin
      startFrame <= sf_nx;
      frameDone  <= fd_nx;
      if (count_inc) frameCount <= frameCount + 16'd1;
      earlyStart <= early_set | (earlyStart & ~clearErrors);
      estStale   <= stale | (estStale & ~clearErrors);
    end
  end

  always_comb begin
    est_bus       = '0;
    est_bus.h0_re = h0InReal;
    est_bus.h0_im = h0InImag;
    est_bus.h1_re = h1InReal;
    est_bus.h1_im = h1InImag;
    est_bus.dtau  = deltaTauIn;
    est_bus.mu0   = mu0In;
    est_bus.mu1   = mu1In;
  end

  stc_est_buffer u_est_buffer (
    .clk      (clk),
    .reset    (reset),
    .clkEn    (clkEn),
    .estValid (estValid),
    .load     (load),
    .est_bus  (est_bus),
    .active   (active),
    .stale    (stale)
  );

  assign h0EstReal   = active.h0_re;
  assign h0EstImag   = active.h0_im;
  assign h1EstReal   = active.h1_re;
  assign h1EstImag   = active.h1_im;
  assign deltaTauEst = active.dtau;
  assign ch0Mu       = active.mu0;
  assign ch1Mu       = active.mu1;

endmodule

// File: tb/tb_stc_frame_sequencer.sv
// Scoreboard bench for stc_frame_sequencer: a frame-level model predicts every
// startFrame/frameDone/pilotEn/dataEn event, and a monitor matches them per cycle.
module tb_stc_frame_sequencer;

  localparam int P = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, clkEn = 1'b1, start = 1'b0, sampleEn = 1'b0;
  logic        estValid = 1'b0, clearErrors = 1'b0;
  logic [17:0] h0InReal = '0, h0InImag = '0, h1InReal = '0, h1InImag = '0;
  logic [5:0]  deltaTauIn = '0;
  logic [17:0] mu0In = '0, mu1In = '0;
  logic [17:0] h0EstReal, h0EstImag, h1EstReal, h1EstImag, ch0Mu, ch1Mu;
  logic [5:0]  deltaTauEst;
  logic        startFrame, pilotEn, dataEn, frameDone, earlyStart, estStale;
  logic [15:0] frameCount;

  stc_frame_sequencer #(.PILOT_BITS(P), .DATA_BITS(D), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .start(start), .sampleEn(sampleEn),
    .estValid(estValid), .h0InReal(h0InReal), .h0InImag(h0InImag),
    .h1InReal(h1InReal), .h1InImag(h1InImag), .deltaTauIn(deltaTauIn),
    .mu0In(mu0In), .mu1In(mu1In), .h0EstReal(h0EstReal), .h0EstImag(h0EstImag),
    .h1EstReal(h1EstReal), .h1EstImag(h1EstImag), .deltaTauEst(deltaTauEst),
    .ch0Mu(ch0Mu), .ch1Mu(ch1Mu), .startFrame(startFrame), .pilotEn(pilotEn),
    .dataEn(dataEn), .frameDone(frameDone), .frameCount(frameCount),
    .clearErrors(clearErrors), .earlyStart(earlyStart), .estStale(estStale)
  );

  typedef struct packed {
    logic [17:0] h0r, h0i, h1r, h1i;
    logic [5:0]  dt;
    logic [17:0] m0, m1;
  } mest_t;

  // kind: 0 startFrame, 1 frameDone, 2 pilotEn, 3 dataEn
  typedef struct {
    int    cyc;
    int    kind;
    mest_t est;
    int    fc;
    bit    early;
    bit    stale;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Frame-level reference state: phase 0 idle, 1 pilot, 2 data; seen = bits counted in field.
  int    ph, seen, fc;
  mest_t act, shd;
  bit    fresh, early, stale, sf, fd;

  function automatic mest_t unity();
    mest_t r;
    r = '0;
    r.h0r = 18'h10000;
    r.h1r = 18'h10000;
    return r;
  endfunction

  function automatic mest_t rnd_est();
    mest_t r;
    r.h0r = 18'($urandom);
    r.h0i = 18'($urandom);
    r.h1r = 18'($urandom);
    r.h1i = 18'($urandom);
    r.dt  = 6'($urandom);
    r.m0  = 18'($urandom);
    r.m1  = 18'($urandom);
    return r;
  endfunction

  function automatic mest_t dut_est();
    mest_t r;
    r.h0r = h0EstReal;
    r.h0i = h0EstImag;
    r.h1r = h1EstReal;
    r.h1i = h1EstImag;
    r.dt  = deltaTauEst;
    r.m0  = ch0Mu;
    r.m1  = ch1Mu;
    return r;
  endfunction

  task automatic push(input int c, input int k);
    exp_t e;
    e.cyc = c; e.kind = k; e.est = act; e.fc = fc; e.early = early; e.stale = stale;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] ex);
    checks++;
    if (a !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, ex);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then let the DUT take the edge.
  task automatic step(input bit rst, input bit ce, input bit st, input bit se,
                      input bit ev, input bit clr, input mest_t e);
    bit ld, eset, sset;
    reset = rst; clkEn = ce; start = st; sampleEn = se; estValid = ev; clearErrors = clr;
    h0InReal = e.h0r; h0InImag = e.h0i; h1InReal = e.h1r; h1InImag = e.h1i;
    deltaTauIn = e.dt; mu0In = e.m0; mu1In = e.m1;
    cyc++;
    if (se && ce && ph == 1) push(cyc, 2);
    if (se && ce && ph == 2) push(cyc, 3);
    if (rst) begin
      ph = 0; seen = 0; act = unity(); shd = unity(); fresh = 0;
      fc = 0; early = 0; stale = 0; sf = 0; fd = 0;
    end else if (ce) begin
      ld = 0; eset = 0; sf = 0; fd = 0;
      case (ph)
        0: if (st) begin ph = 1; seen = 0; end
        1: begin
          if (st) seen = 0;
          else if (se) begin
            seen++;
            if (seen == P) begin ph = 2; seen = 0; ld = 1; sf = 1; end
          end
        end
        default: begin
          if (se && seen == D - 1) begin
            fd = 1; fc = (fc + 1) % 65536; ph = st ? 1 : 0; seen = 0;
          end else if (st) begin
            eset = 1; ph = 1; seen = 0;
          end else if (se) seen++;
        end
      endcase
      sset = ld && !fresh && !ev;
      if (ld) begin
        if (ev) act = e;
        else if (fresh) act = shd;
      end
      if (ev) shd = e;
      fresh = ld ? 1'b0 : (fresh | ev);
      early = eset | (early & !clr);
      stale = sset | (stale & !clr);
    end
    if (sf) push(cyc + 1, 0);
    if (fd) push(cyc + 1, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, rnd_est());
  endtask

  task automatic samp(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 1, 0, 0, rnd_est());
  endtask

  // Monitor: whenever an event is present (actual or expected) compare it.
  bit    mon_act[4];
  bit    mon_exp[4];
  exp_t  mon_ep[4];
  exp_t  mon_e;
  string kname[4] = '{"startFrame", "frameDone", "pilotEn", "dataEn"};

  initial begin
    forever begin
      @(negedge clk);
      mon_act[0] = (startFrame === 1'b1);
      mon_act[1] = (frameDone === 1'b1);
      mon_act[2] = (pilotEn === 1'b1);
      mon_act[3] = (dataEn === 1'b1);
      for (int k = 0; k < 4; k++) mon_exp[k] = 1'b0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        mon_exp[mon_e.kind] = 1'b1;
        mon_ep[mon_e.kind]  = mon_e;
      end
      for (int k = 0; k < 4; k++) begin
        if (mon_act[k] || mon_exp[k]) begin
          checks++;
          if (mon_act[k] != mon_exp[k]) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", kname[k], cyc, mon_act[k], mon_exp[k]);
          end else begin
            checks++;
            if (dut_est() !== mon_ep[k].est || frameCount !== 16'(mon_ep[k].fc) ||
                earlyStart !== mon_ep[k].early || estStale !== mon_ep[k].stale) begin
              errors++;
              $display("FAIL %s_state cyc %0d: got est=%h fc=%0d es=%b st=%b expected est=%h fc=%0d es=%b st=%b",
                       kname[k], cyc, dut_est(), frameCount, earlyStart, estStale,
                       mon_ep[k].est, mon_ep[k].fc, mon_ep[k].early, mon_ep[k].stale);
            end
          end
        end
      end
    end
  end

  initial begin
    mest_t e;
    bit r_rst, r_ce, r_st, r_se, r_ev, r_clr;
    ph = 0; seen = 0; act = unity(); shd = unity(); fresh = 0;
    fc = 0; early = 0; stale = 0; sf = 0; fd = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, '0);
    chk("reset_h0re", 32'(h0EstReal), 32'h10000);
    chk("reset_h1re", 32'(h1EstReal), 32'h10000);
    chk("reset_fc", 32'(frameCount), 32'd0);
    chk("reset_flags", {30'd0, earlyStart, estStale}, 32'd0);

    // Nominal frame
    step(0, 1, 1, 0, 0, 0, rnd_est());
    e = rnd_est(); e.h0r = 18'h08000;
    step(0, 1, 0, 0, 1, 0, e);
    samp(P + D);
    idle(2);
    chk("nominal_h0re", 32'(h0EstReal), 32'h08000);
    chk("nominal_fc", 32'(frameCount), 32'd1);
    chk("nominal_stale", 32'(estStale), 32'd0);

    // Stale: no estimate during second frame
    step(0, 1, 1, 0, 0, 0, rnd_est());
    samp(P + D);
    idle(2);
    chk("stale_set", 32'(estStale), 32'd1);
    chk("stale_h0re", 32'(h0EstReal), 32'h08000);
    step(0, 1, 0, 0, 0, 1, rnd_est());
    chk("stale_clear", 32'(estStale), 32'd0);

    // Bypass on the terminal pilot sample
    step(0, 1, 1, 0, 0, 0, rnd_est());
    samp(P - 1);
    e = rnd_est(); e.h1r = 18'h04000;
    step(0, 1, 0, 1, 1, 0, e);
    chk("bypass_h1re", 32'(h1EstReal), 32'h04000);
    chk("bypass_stale", 32'(estStale), 32'd0);
    samp(D);
    idle(2);

    // Early start after 3 data samples
    step(0, 1, 1, 0, 0, 0, rnd_est());
    samp(P + 3);
    step(0, 1, 1, 0, 0, 0, rnd_est());
    chk("early_set", 32'(earlyStart), 32'd1);
    samp(P + D);
    idle(2);
    chk("early_fc", 32'(frameCount), 32'(fc));
    step(0, 1, 0, 0, 0, 1, rnd_est());
    chk("early_clear", 32'(earlyStart), 32'd0);

    // Start coincident with terminal data sample
    step(0, 1, 1, 0, 0, 0, rnd_est());
    samp(P + D - 1);
    step(0, 1, 1, 1, 0, 0, rnd_est());
    chk("boundary_early", 32'(earlyStart), 32'd0);
    chk("boundary_fd", 32'(frameDone), 32'd1);
    samp(P + D);
    idle(2);

    // clkEn low mid-DATA with sampleEn high
    step(0, 1, 1, 0, 0, 0, rnd_est());
    samp(P + 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, rnd_est());
    samp(D - 3);
    idle(2);
    chk("clken_fc", 32'(frameCount), 32'(fc));

    // Reset mid-DATA
    step(0, 1, 1, 0, 0, 0, rnd_est());
    step(0, 1, 0, 0, 1, 0, rnd_est());
    samp(P + 2);
    step(1, 1, 0, 0, 0, 0, rnd_est());
    chk("rst_mid_h0re", 32'(h0EstReal), 32'h10000);
    chk("rst_mid_fc", 32'(frameCount), 32'd0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(999) < 3);
      r_ce  = ($urandom_range(99) < 90);
      r_st  = ($urandom_range(99) < 3);
      r_se  = ($urandom_range(99) < 50);
      r_ev  = ($urandom_range(99) < 10);
      r_clr = ($urandom_range(99) < 3);
      step(r_rst, r_ce, r_st, r_se, r_ev, r_clr, rnd_est());
    end
    idle(3);
    chk("final_fc", 32'(frameCount), 32'(fc));
    chk("final_flags", {30'd0, earlyStart, estStale}, {30'd0, early, stale});
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
